imem_access_ctrl: RTL and testbench

//  Sequences all access to the word-addressed instruction memory. Normal mode
//  (RUN) serves CPU fetch reads. Program-load mode (LOAD) takes write traffic

---
 rtl/imem_access_ctrl_if.sv | 39 +++
 rtl/imem_access_ctrl.sv | 101 ++++++++++
 tb/tb_imem_access_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/imem_access_ctrl_if.sv
// Fetch, loader and memory-port signal bundle for the instruction memory controller.
// Pure wiring; no state and no latency.
// Flow control is positional only: the loader and fetch sides have no ready, so stall gates the CPU.
interface imem_access_ctrl_if #(
   parameter int IDX_W = 8
);
   logic              fetch_req;
   logic [31:0]       fetch_addr;
   logic              fetch_valid;
   logic [31:0]       fetch_instr;
   logic              fetch_err;
   logic              cpu_stall;
   logic              ld_start;
   logic              ld_wr;
   logic [31:0]       ld_addr;
   logic [31:0]       ld_wdata;
   logic              ld_end;
   logic              ld_err;
   logic              ld_timeout;
   logic [IDX_W:0]    ld_count;
   logic [31:0]       mem_addr;
   logic              mem_we;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   // controller side
   modport master (
      input  fetch_req, fetch_addr, ld_start, ld_wr, ld_addr, ld_wdata, ld_end, mem_rdata,
      output fetch_valid, fetch_instr, fetch_err, cpu_stall, ld_err, ld_timeout, ld_count,
             mem_addr, mem_we, mem_wdata
   );

   // CPU / loader / memory side
   modport slave (
      output fetch_req, fetch_addr, ld_start, ld_wr, ld_addr, ld_wdata, ld_end, mem_rdata,
      input  fetch_valid, fetch_instr, fetch_err, cpu_stall, ld_err, ld_timeout, ld_count,
             mem_addr, mem_we, mem_wdata
   );
endinterface

// File: rtl/imem_access_ctrl.sv
// Arbitrates the single instruction-memory port between CPU fetch (RUN) and boot-loader writes (LOAD).
// Fetch latency 1 cycle, back-to-back; loader writes land on the same clock edge they are presented.
// CPU is held via cpu_stall during LOAD and FLUSH; bad loader writes are dropped and flagged.
module imem_access_ctrl #(
   parameter int DEPTH      = 256,
   parameter int IDX_W      = 8,
   parameter int LD_TIMEOUT = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   imem_access_ctrl_if.master   bus
);
   localparam int CNT_W = $clog2(LD_TIMEOUT + 1);

   typedef enum logic [1:0] {RUN, LOAD, FLUSH} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  idle_cnt;
   logic              ld_addr_ok;
   logic              fetch_bad;
   logic              timeout_hit;

   // DEPTH is a power of two, so "index >= DEPTH" reduces to any bit above the index being set
   assign ld_addr_ok  = (bus.ld_addr[1:0] == 2'b00) && (bus.ld_addr[31:IDX_W+2] == '0);
   assign fetch_bad   = (bus.fetch_addr[1:0] != 2'b00) || (bus.fetch_addr[31:IDX_W+2] != '0);
   // the idle cycle that would bring the counter to LD_TIMEOUT-1 is the last LOAD cycle
   assign timeout_hit = (state == LOAD) && !bus.ld_wr && (idle_cnt == CNT_W'(LD_TIMEOUT - 2));

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RUN;
      else     state <= state_nxt;
   end

   // next-state and memory-port steering
   always_comb begin
      state_nxt     = state;
      bus.cpu_stall = 1'b0;
      bus.mem_addr  = bus.fetch_addr;
      bus.mem_we    = 1'b0;
      bus.mem_wdata = '0;
      case (state)
         RUN: begin
            if (bus.ld_start) state_nxt = LOAD;
         end
         LOAD: begin
            bus.cpu_stall = 1'b1;
            bus.mem_addr  = bus.ld_addr;
            bus.mem_wdata = bus.ld_wdata;
            bus.mem_we    = bus.ld_wr && ld_addr_ok && !rst;
            if (bus.ld_end || timeout_hit) state_nxt = FLUSH;
         end
         FLUSH: begin
            bus.cpu_stall = 1'b1;
            state_nxt     = RUN;
         end
         default: state_nxt = RUN;
      endcase
   end

   // fetch response register: only RUN serves fetches
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.fetch_valid <= 1'b0;
         bus.fetch_instr <= '0;
         bus.fetch_err   <= 1'b0;
      end else if (state == RUN && bus.fetch_req) begin
         bus.fetch_valid <= 1'b1;
         bus.fetch_err   <= fetch_bad;
         bus.fetch_instr <= fetch_bad ? 32'h0000_0000 : bus.mem_rdata;
      end else begin
         bus.fetch_valid <= 1'b0;
      end
   end

   // load bookkeeping: cleared on entry to LOAD, held afterwards until the next load
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.ld_count   <= '0;
         bus.ld_err     <= 1'b0;
         bus.ld_timeout <= 1'b0;
         idle_cnt       <= '0;
      end else if (state == RUN && bus.ld_start) begin
         bus.ld_count   <= '0;
         bus.ld_err     <= 1'b0;
         bus.ld_timeout <= 1'b0;
         idle_cnt       <= '0;
      end else if (state == LOAD) begin
         if (bus.ld_wr) begin
            idle_cnt <= '0;
            if (!ld_addr_ok)
               bus.ld_err <= 1'b1;
            else if (bus.ld_count < (IDX_W+1)'(DEPTH))
               bus.ld_count <= bus.ld_count + 1'b1;
         end else begin
            idle_cnt <= idle_cnt + 1'b1;
            if (timeout_hit) bus.ld_timeout <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_imem_access_ctrl.sv
// Scoreboard bench for imem_access_ctrl: directed fetch/load/timeout/reset vectors.
// Fetch responses are queued at issue time and popped by a negedge monitor on fetch_valid.
// Scalar status (stall, ld_* flags, mem_we) is checked directly one step after each edge.
module tb_imem_access_ctrl;
   localparam int DEPTH = 256;
   localparam int IDX_W = 8;
   localparam int LD_TO = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   imem_access_ctrl_if #(.IDX_W(IDX_W)) bus ();

   imem_access_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W), .LD_TIMEOUT(LD_TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // instruction memory model: combinational read, write at clock edge
   logic [31:0] mem [DEPTH];
   assign bus.mem_rdata = mem[bus.mem_addr[IDX_W+1:2]];
   always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[IDX_W+1:2]] <= bus.mem_wdata;

   int compared   = 0;
   int mismatched = 0;
   logic [32:0] exp_q [$];   // {err, instr}

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // monitor: every fetch_valid must match the oldest expected response
   always @(negedge clk) begin
      if (!rst && bus.fetch_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_fetch_valid: got instr %h err %b expected no response",
                     bus.fetch_instr, bus.fetch_err);
         end else begin
            chk("fetch_resp", {31'd0, bus.fetch_err, bus.fetch_instr}, {31'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [31:0] addr, input logic err, input logic [31:0] instr);
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = addr;
      exp_q.push_back({err, instr});
      tick();
      bus.fetch_req  = 1'b0;
   endtask

   task automatic ld_write(input logic [31:0] addr, input logic [31:0] data, input logic we_exp);
      bus.ld_wr    = 1'b1;
      bus.ld_addr  = addr;
      bus.ld_wdata = data;
      #1;
      chk("mem_we", 64'(bus.mem_we), 64'(we_exp));
      tick();
      bus.ld_wr    = 1'b0;
   endtask

   task automatic start_load();
      bus.ld_start = 1'b1;
      tick();
      bus.ld_start = 1'b0;
   endtask

   task automatic end_load();
      bus.ld_end = 1'b1;
      tick();
      bus.ld_end = 1'b0;
      chk("stall_flush", 64'(bus.cpu_stall), 64'd1);
      tick();
      chk("stall_run", 64'(bus.cpu_stall), 64'd0);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = {8'h00, 24'(i)} | 32'h1111_0000;
      mem[0] = 32'h2008_0005;
      mem[1] = 32'h1111_1111;
      mem[2] = 32'h2222_2222;
      mem[3] = 32'h3333_3333;
      bus.fetch_req = 1'b0; bus.fetch_addr = '0;
      bus.ld_start = 1'b0; bus.ld_wr = 1'b0; bus.ld_addr = '0; bus.ld_wdata = '0; bus.ld_end = 1'b0;

      // reset state
      #12;
      chk("rst_fetch_valid", 64'(bus.fetch_valid), 64'd0);
      chk("rst_fetch_instr", 64'(bus.fetch_instr), 64'd0);
      chk("rst_stall", 64'(bus.cpu_stall), 64'd0);
      chk("rst_ld_count", 64'(bus.ld_count), 64'd0);
      chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
      rst = 1'b0;
      tick();

      // 1: single fetch then back-to-back
      fetch(32'h0, 1'b0, 32'h2008_0005);
      fetch(32'h4, 1'b0, 32'h1111_1111);
      fetch(32'h8, 1'b0, 32'h2222_2222);
      tick();

      // 2: misaligned and out of range
      fetch(32'h2,   1'b1, 32'h0);
      fetch(32'h400, 1'b1, 32'h0);
      tick();

      // 3: load two words, then fetch freshly written data
      start_load();
      chk("stall_load", 64'(bus.cpu_stall), 64'd1);
      ld_write(32'h0, 32'hAAAA_0001, 1'b1);
      ld_write(32'h4, 32'hAAAA_0002, 1'b1);
      chk("ld_count_2", 64'(bus.ld_count), 64'd2);
      end_load();
      chk("ld_count_hold", 64'(bus.ld_count), 64'd2);
      fetch(32'h4, 1'b0, 32'hAAAA_0002);
      tick();

      // 4: bad loader address dropped
      start_load();
      chk("ld_count_clear", 64'(bus.ld_count), 64'd0);
      ld_write(32'h8,   32'hBBBB_0003, 1'b1);
      ld_write(32'h401, 32'hDEAD_BEEF, 1'b0);
      chk("ld_err_set", 64'(bus.ld_err), 64'd1);
      chk("ld_count_1", 64'(bus.ld_count), 64'd1);
      end_load();
      fetch(32'h8, 1'b0, 32'hBBBB_0003);
      tick();

      // 5: timeout with LD_TIMEOUT=8; fetch_req held during LOAD/FLUSH must be ignored
      start_load();
      chk("ld_err_clear", 64'(bus.ld_err), 64'd0);
      bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0;
      for (int i = 0; i < 6; i++) tick();
      chk("to_not_yet", 64'(bus.ld_timeout), 64'd0);
      chk("to_still_load", 64'(bus.cpu_stall), 64'd1);
      tick();
      chk("to_set", 64'(bus.ld_timeout), 64'd1);
      chk("to_flush_stall", 64'(bus.cpu_stall), 64'd1);
      tick();
      bus.fetch_req = 1'b0;
      chk("to_run_stall", 64'(bus.cpu_stall), 64'd0);
      chk("to_hold", 64'(bus.ld_timeout), 64'd1);
      tick();

      // 6: reset mid-LOAD with a write pending
      start_load();
      bus.ld_wr = 1'b1; bus.ld_addr = 32'hC; bus.ld_wdata = 32'hDEAD_0000;
      #1;
      chk("pre_rst_we", 64'(bus.mem_we), 64'd1);
      rst = 1'b1;
      #1;
      chk("rst_we_low", 64'(bus.mem_we), 64'd0);
      chk("rst_stall_low", 64'(bus.cpu_stall), 64'd0);
      tick();
      bus.ld_wr = 1'b0;
      chk("rst_ld_timeout", 64'(bus.ld_timeout), 64'd0);
      chk("rst_fetch_instr2", 64'(bus.fetch_instr), 64'd0);
      rst = 1'b0;
      tick();
      fetch(32'hC, 1'b0, 32'h3333_3333);

      // drain scoreboard with a bounded wait
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
      if (exp_q.size() != 0) begin
         compared++;
         mismatched++;
         $display("FAIL drain: got %0d outstanding responses expected 0", exp_q.size());
      end
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
